// File: rtl/phy_rx_lanes.sv
// phy_rx_lanes: multi-lane serial receiver on a single bit-rate clock.
// Each lane deserialises MSB-first, hunts for a comma, and after SYNC_COUNT
// aligned commas pushes its non-comma bytes into a small deskew FIFO.
// Once every lane is active and holds a byte, one column (a byte per lane)
// is popped and packed into a WORD_W-bit word, with the first byte in the MSB.
//
// Lane state | meaning
// SEARCH     | hunting for COMMA at any bit offset
// LOCK       | byte boundary assumed, counting consecutive aligned commas
// ACTIVE     | aligned; commas are idle, every other byte goes to the FIFO
module phy_rx_lanes #(
   parameter int         LANES      = 2,
   parameter int         WORD_W     = 32,
   parameter logic [7:0] COMMA      = 8'hBC,
   parameter int         SYNC_COUNT = 4,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic              clk_32f,
   input  logic              reset,
   input  logic [LANES-1:0]  par_ser,
   output logic [LANES-1:0]  active_ser_par,
   output logic              valid_output,
   output logic [WORD_W-1:0] data_output,
   output logic              overflow_err
);
   localparam int COL_W = 8 * LANES;
   localparam int COLS  = WORD_W / COL_W;
   localparam int CW    = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;
   localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int NW    = $clog2(FIFO_DEPTH + 1);
   localparam int KW    = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_LOCK   = 2'd1,
      ST_ACTIVE = 2'd2
   } lane_state_t;

   logic [7:0]        w_head [LANES];
   logic [LANES-1:0]  w_lane_active;
   logic [LANES-1:0]  w_empty;
   logic [LANES-1:0]  w_drop;
   logic              w_pop;
   logic [COL_W-1:0]  w_column;
   logic [WORD_W-1:0] w_next_word;
   logic [WORD_W-1:0] r_word;
   logic [KW-1:0]     r_col;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [7:0]    r_sr;
         lane_state_t   r_state;
         logic [2:0]    r_bit_cnt;
         logic [CW-1:0] r_comma_cnt;
         logic [7:0]    r_mem [FIFO_DEPTH];
         logic [AW-1:0] r_wptr;
         logic [AW-1:0] r_rptr;
         logic [NW-1:0] r_count;
         logic          w_push;
         logic          w_full;
         logic          w_wr;

         // a data byte is complete when the bit counter wraps in ACTIVE
         assign w_push             = (r_state == ST_ACTIVE) && (r_bit_cnt == 3'd7) && (r_sr != COMMA);
         assign w_full             = (r_count == NW'(FIFO_DEPTH));
         // a full FIFO still accepts a byte when a column leaves on the same edge
         assign w_wr               = w_push && (!w_full || w_pop);
         assign w_drop[gi]         = w_push && w_full && !w_pop;
         assign w_empty[gi]        = (r_count == '0);
         assign w_lane_active[gi]  = (r_state == ST_ACTIVE);
         assign w_head[gi]         = r_mem[r_rptr];

         // deserialiser and alignment state machine
         always_ff @(posedge clk_32f or posedge reset) begin
            if (reset) begin
               r_sr        <= '0;
               r_state     <= ST_SEARCH;
               r_bit_cnt   <= '0;
               r_comma_cnt <= '0;
            end else begin
               r_sr      <= {r_sr[6:0], par_ser[gi]};
               r_bit_cnt <= r_bit_cnt + 3'd1;
               case (r_state)
                  ST_SEARCH: begin
                     if (r_sr == COMMA) begin
                        r_bit_cnt   <= '0;
                        r_comma_cnt <= CW'(1);
                        r_state     <= (SYNC_COUNT == 1) ? ST_ACTIVE : ST_LOCK;
                     end
                  end
                  ST_LOCK: begin
                     if (r_bit_cnt == 3'd7) begin
                        if (r_sr == COMMA) begin
                           if (r_comma_cnt == CW'(SYNC_COUNT - 1)) r_state <= ST_ACTIVE;
                           else r_comma_cnt <= r_comma_cnt + 1'b1;
                        end else begin
                           r_comma_cnt <= '0;
                           r_state     <= ST_SEARCH;
                        end
                     end
                  end
                  ST_ACTIVE: r_state <= ST_ACTIVE;
                  default:   r_state <= ST_SEARCH;
               endcase
            end
         end

         // deskew FIFO pointers and occupancy
         always_ff @(posedge clk_32f or posedge reset) begin
            if (reset) begin
               r_wptr  <= '0;
               r_rptr  <= '0;
               r_count <= '0;
            end else begin
               if (w_wr)  r_wptr <= ptr_inc(r_wptr);
               if (w_pop) r_rptr <= ptr_inc(r_rptr);
               if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
               else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
            end
         end

         // deskew FIFO storage, no reset needed behind the pointers
         always_ff @(posedge clk_32f) begin
            if (w_wr) r_mem[r_wptr] <= r_sr;
         end
      end
   endgenerate

   assign active_ser_par = w_lane_active;
   assign w_pop          = (&w_lane_active) && !(|w_empty);
   assign w_next_word    = (r_word << COL_W) | WORD_W'(w_column);

   // lane 0 occupies the most significant byte of each column
   always_comb begin
      w_column = '0;
      for (int l = 0; l < LANES; l++) begin
         w_column[COL_W-1-8*l -: 8] = w_head[l];
      end
   end

   // word assembler: shift columns in, publish on the last one
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         r_word       <= '0;
         r_col        <= '0;
         data_output  <= '0;
         valid_output <= 1'b0;
      end else begin
         valid_output <= 1'b0;
         if (w_pop) begin
            r_word <= w_next_word;
            if (r_col == KW'(COLS - 1)) begin
               r_col        <= '0;
               data_output  <= w_next_word;
               valid_output <= 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
      end
   end

   // sticky record of any byte lost to a full FIFO
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) overflow_err <= 1'b0;
      else       overflow_err <= overflow_err | (|w_drop);
   end

endmodule

// File: tb/tb_phy_rx_lanes.sv
`timescale 1ns/1ps
// Bench for phy_rx_lanes: serial bit streams per lane, outputs sampled on the
// falling edge and compared with a byte-list model of the word packing.
module tb_phy_rx_lanes;
   localparam int         LANES       = 2;
   localparam int         WORD_W      = 32;
   localparam int         SYNC_COUNT  = 4;
   localparam int         FIFO_DEPTH  = 4;
   localparam logic [7:0] COMMA       = 8'hBC;
   localparam int         BPL         = WORD_W / (8 * LANES);
   localparam int         WORD_CYCLES = WORD_W / LANES;

   logic              clk_32f = 1'b0;
   logic              reset   = 1'b0;
   logic [LANES-1:0]  par_ser = '0;
   logic [LANES-1:0]  active_ser_par;
   logic              valid_output;
   logic [WORD_W-1:0] data_output;
   logic              overflow_err;

   phy_rx_lanes #(
      .LANES(LANES), .WORD_W(WORD_W), .COMMA(COMMA),
      .SYNC_COUNT(SYNC_COUNT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk_32f(clk_32f), .reset(reset), .par_ser(par_ser),
      .active_ser_par(active_ser_par), .valid_output(valid_output),
      .data_output(data_output), .overflow_err(overflow_err)
   );

   always #5 clk_32f = ~clk_32f;

   typedef struct {
      int                c;
      logic [WORD_W-1:0] d;
   } strobe_t;

   int                errors = 0;
   int                checks = 0;
   int                cyc    = 0;
   logic              lane_q [LANES][$];
   bit                idle_comma [LANES];
   logic [7:0]        sent [LANES][$];
   logic [WORD_W-1:0] exp_q [$];
   strobe_t           strobes [$];
   int                first_act [LANES];
   int                first_ovf;

   task automatic clear_logs();
      strobes.delete();
      exp_q.delete();
      first_ovf = -1;
      for (int l = 0; l < LANES; l++) begin
         first_act[l] = -1;
         sent[l].delete();
      end
   endtask

   task automatic push_byte(input int l, input logic [7:0] b);
      for (int k = 7; k >= 0; k--) lane_q[l].push_back(b[k]);
   endtask

   task automatic push_zeros(input int l, input int n);
      for (int k = 0; k < n; k++) lane_q[l].push_back(1'b0);
   endtask

   task automatic send_data(input int l, input logic [7:0] b);
      push_byte(l, b);
      sent[l].push_back(b);
   endtask

   function automatic logic [7:0] rnd_data();
      logic [7:0] b;
      do b = 8'($urandom_range(0, 255)); while (b == COMMA);
      return b;
   endfunction

   // reference: word k = column bytes in arrival order, lane 0 first, MSB first
   task automatic build_expected();
      int n;
      logic [WORD_W-1:0] w;
      exp_q.delete();
      n = sent[0].size() / BPL;
      for (int k = 0; k < n; k++) begin
         w = '0;
         for (int b = 0; b < BPL; b++)
            for (int l = 0; l < LANES; l++)
               w = {w[WORD_W-9:0], sent[l][k*BPL+b]};
         exp_q.push_back(w);
      end
   endtask

   // one iteration per bit: sample outputs, then drive the next bit of each lane
   task automatic run(input int n);
      strobe_t s;
      for (int k = 0; k < n; k++) begin
         @(negedge clk_32f);
         if (valid_output === 1'b1) begin
            s.c = cyc;
            s.d = data_output;
            strobes.push_back(s);
         end
         for (int l = 0; l < LANES; l++)
            if (active_ser_par[l] === 1'b1 && first_act[l] < 0) first_act[l] = cyc;
         if (overflow_err === 1'b1 && first_ovf < 0) first_ovf = cyc;
         for (int l = 0; l < LANES; l++) begin
            if (lane_q[l].size() == 0 && idle_comma[l]) push_byte(l, COMMA);
            if (lane_q[l].size() != 0) par_ser[l] = lane_q[l].pop_front();
            else                       par_ser[l] = 1'b0;
         end
         cyc++;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk_32f);
      reset   = 1'b1;
      par_ser = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_q[l].delete();
         idle_comma[l] = 1'b0;
      end
      repeat (2) @(negedge clk_32f);
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic load_stream(input int late_lane, input int late_bits, input int nwords, input bit with_idle);
      bit idle_slot [$];
      for (int k = 0; k < nwords * BPL; k++)
         idle_slot.push_back(with_idle && ($urandom_range(0, 2) == 0));
      for (int l = 0; l < LANES; l++) begin
         idle_comma[l] = 1'b1;
         if (l == late_lane) push_zeros(l, late_bits);
         repeat (SYNC_COUNT) push_byte(l, COMMA);
         for (int k = 0; k < nwords * BPL; k++) begin
            if (idle_slot[k]) push_byte(l, COMMA);
            send_data(l, rnd_data());
         end
      end
      build_expected();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (active_ser_par !== '0) begin errors++; $display("FAIL reset_active: got %b expected 0", active_ser_par); end
      checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_output); end
      checks++; if (data_output !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_output); end
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow_err); end
      apply_reset();
      run(100);
      checks++; if (strobes.size() !== 0) begin errors++; $display("FAIL idle_strobes: got %0d expected 0", strobes.size()); end
      checks++; if (first_act[0] !== -1 || first_act[1] !== -1) begin errors++; $display("FAIL idle_active: got %0d/%0d expected -1/-1", first_act[0], first_act[1]); end
      checks++; if (first_ovf !== -1) begin errors++; $display("FAIL idle_overflow: got cycle %0d expected none", first_ovf); end
   endtask

   task automatic test_basic();
      int s;
      apply_reset();
      s = cyc;
      for (int l = 0; l < LANES; l++) begin
         idle_comma[l] = 1'b1;
         repeat (SYNC_COUNT) push_byte(l, COMMA);
      end
      send_data(0, 8'h12); send_data(0, 8'h56);
      send_data(1, 8'h34); send_data(1, 8'h78);
      run(90);
      checks++; if (first_act[0] !== s + 33) begin errors++; $display("FAIL basic_act0_cycle: got %0d expected %0d", first_act[0] - s, 33); end
      checks++; if (first_act[1] !== s + 33) begin errors++; $display("FAIL basic_act1_cycle: got %0d expected %0d", first_act[1] - s, 33); end
      checks++; if (active_ser_par !== 2'b11) begin errors++; $display("FAIL basic_active: got %b expected 11", active_ser_par); end
      checks++; if (strobes.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", strobes.size()); end
      if (strobes.size() > 0) begin
         checks++; if (strobes[0].d !== 32'h12345678) begin errors++; $display("FAIL basic_word: got %h expected 12345678", strobes[0].d); end
         checks++; if (strobes[0].c !== s + 50) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", strobes[0].c - s, 50); end
      end
      checks++; if (data_output !== 32'h12345678) begin errors++; $display("FAIL basic_hold: got %h expected 12345678", data_output); end
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b expected 0", overflow_err); end
   endtask

   task automatic test_skew();
      apply_reset();
      for (int l = 0; l < LANES; l++) idle_comma[l] = 1'b1;
      repeat (SYNC_COUNT) push_byte(0, COMMA);
      push_zeros(1, 11);
      repeat (SYNC_COUNT) push_byte(1, COMMA);
      send_data(0, 8'h12); send_data(0, 8'h56);
      send_data(1, 8'h34); send_data(1, 8'h78);
      run(100);
      checks++; if (strobes.size() !== 1) begin errors++; $display("FAIL skew11_count: got %0d expected 1", strobes.size()); end
      if (strobes.size() > 0) begin
         checks++; if (strobes[0].d !== 32'h12345678) begin errors++; $display("FAIL skew11_word: got %h expected 12345678", strobes[0].d); end
      end
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL skew11_overflow: got %b expected 0", overflow_err); end
      // 31 bits of skew makes the leading FIFO full exactly when the first column leaves
      for (int late = 0; late < LANES; late++) begin
         apply_reset();
         load_stream(late, 31, 4, 1'b0);
         run(200);
         checks++; if (strobes.size() !== exp_q.size()) begin errors++; $display("FAIL skew31_count: lane %0d got %0d expected %0d", late, strobes.size(), exp_q.size()); end
         for (int k = 0; k < strobes.size() && k < exp_q.size(); k++) begin
            checks++; if (strobes[k].d !== exp_q[k]) begin errors++; $display("FAIL skew31_word: lane %0d word %0d got %h expected %h", late, k, strobes[k].d, exp_q[k]); end
         end
         checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL skew31_overflow: lane %0d got %b expected 0", late, overflow_err); end
      end
   endtask

   task automatic test_resync();
      int s;
      apply_reset();
      s = cyc;
      idle_comma[0] = 1'b1;
      repeat (3) push_byte(0, COMMA);
      push_byte(0, 8'h00);
      repeat (SYNC_COUNT) push_byte(0, COMMA);
      run(90);
      checks++; if (first_act[0] !== s + 65) begin errors++; $display("FAIL resync_act_cycle: got %0d expected %0d", first_act[0] - s, 65); end
      checks++; if (active_ser_par !== 2'b01) begin errors++; $display("FAIL resync_active: got %b expected 01", active_ser_par); end
   endtask

   task automatic test_overflow();
      int s;
      apply_reset();
      s = cyc;
      idle_comma[0] = 1'b1;
      repeat (SYNC_COUNT) push_byte(0, COMMA);
      for (int k = 1; k <= 5; k++) send_data(0, 8'(k));
      run(110);
      checks++; if (first_ovf !== s + 73) begin errors++; $display("FAIL overflow_cycle: got %0d expected %0d", first_ovf - s, 73); end
      checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b expected 1", overflow_err); end
      checks++; if (strobes.size() !== 0) begin errors++; $display("FAIL overflow_strobes: got %0d expected 0", strobes.size()); end
      checks++; if (active_ser_par !== 2'b01) begin errors++; $display("FAIL overflow_active: got %b expected 01", active_ser_par); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         apply_reset();
         load_stream($urandom_range(0, LANES - 1), $urandom_range(0, 24), 5, 1'b1);
         run(340);
         checks++; if (strobes.size() !== exp_q.size()) begin errors++; $display("FAIL random_count: iter %0d got %0d expected %0d", it, strobes.size(), exp_q.size()); end
         for (int k = 0; k < strobes.size() && k < exp_q.size(); k++) begin
            checks++; if (strobes[k].d !== exp_q[k]) begin errors++; $display("FAIL random_word: iter %0d word %0d got %h expected %h", it, k, strobes[k].d, exp_q[k]); end
         end
         checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL random_overflow: iter %0d got %b expected 0", it, overflow_err); end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      load_stream(-1, 0, 6, 1'b0);
      run(220);
      checks++; if (strobes.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", strobes.size(), exp_q.size()); end
      for (int k = 0; k < strobes.size() && k < exp_q.size(); k++) begin
         checks++; if (strobes[k].d !== exp_q[k]) begin errors++; $display("FAIL b2b_word: word %0d got %h expected %h", k, strobes[k].d, exp_q[k]); end
         if (k > 0) begin
            checks++; if (strobes[k].c - strobes[k-1].c !== WORD_CYCLES) begin errors++; $display("FAIL b2b_spacing: word %0d got %0d expected %0d", k, strobes[k].c - strobes[k-1].c, WORD_CYCLES); end
         end
      end
   endtask

   task automatic test_reset_midword();
      apply_reset();
      for (int l = 0; l < LANES; l++) begin
         idle_comma[l] = 1'b1;
         repeat (SYNC_COUNT) push_byte(l, COMMA);
      end
      send_data(0, 8'hAA);
      send_data(1, 8'hBB);
      run(50);
      checks++; if (strobes.size() !== 0) begin errors++; $display("FAIL midword_early: got %0d expected 0", strobes.size()); end
      @(posedge clk_32f);
      #2 reset = 1'b1;
      #1;
      checks++; if (active_ser_par !== '0) begin errors++; $display("FAIL midword_async_active: got %b expected 0", active_ser_par); end
      checks++; if (data_output !== '0) begin errors++; $display("FAIL midword_async_data: got %h expected 0", data_output); end
      apply_reset();
      for (int l = 0; l < LANES; l++) begin
         idle_comma[l] = 1'b1;
         repeat (SYNC_COUNT) push_byte(l, COMMA);
      end
      send_data(0, 8'h11); send_data(0, 8'h33);
      send_data(1, 8'h22); send_data(1, 8'h44);
      run(90);
      checks++; if (strobes.size() !== 1) begin errors++; $display("FAIL midword_count: got %0d expected 1", strobes.size()); end
      if (strobes.size() > 0) begin
         checks++; if (strobes[0].d !== 32'h11223344) begin errors++; $display("FAIL midword_word: got %h expected 11223344", strobes[0].d); end
      end
   endtask

   initial begin
      clear_logs();
      test_reset();
      test_basic();
      test_skew();
      test_resync();
      test_overflow();
      test_random();
      test_back_to_back();
      test_reset_midword();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
